rr_decode_arbiter: RTL
======================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one 8-way decoded resource (chip-select / enable bus) among 8 requesters.
- Selects one requester, holds a 3-bit grant index, and drives the matching one-hot 3-to-8 decoded grant line.
- Grant is released when the owner signals done, drops its request, or exceeds a hold-time limit.
- Sits between the requester agents and the shared decoded-select datapath.

Parameters:
- HOLD_MAX, 16: maximum cycles a grant is held before forced release; legal range 2..256.
- CW, $clog2(HOLD_MAX): hold counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit k = requester k.
- done  input  1  single-cycle release strobe from the current owner; ignored when no grant is active.
- gnt  output  8  one-hot grant, equal to 3-to-8 decode of gnt_idx when gnt_valid=1, else 0.
- gnt_idx  output  3  index of current owner.
- gnt_valid  output  1  grant active.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; ptr=0; cnt=0; gnt=8'h00; gnt_idx=0; gnt_valid=0; timeout=0.
- All outputs are registered. gnt must never be nonzero while gnt_valid=0, and never has more than one bit set.
- State IDLE:
  - If req != 0, the winner is the first set bit scanning ptr, ptr+1, ... mod 8 (wrap 7 -> 0).
  - At the next edge: state=GRANT, gnt_idx=winner, gnt=1<<winner, gnt_valid=1, cnt=0.
  - If req == 0, stay in IDLE.
- Latency: request sampled in IDLE on cycle N gives gnt visible in cycle N+1.
- State GRANT: cnt increments each cycle, saturating at HOLD_MAX-1. The release condition is checked at each edge in priority order:
  1. done=1 -> normal release.
  2. req[gnt_idx]=0 -> normal release (owner abandoned).
  3. cnt == HOLD_MAX-1 -> forced release; timeout=1 for exactly one cycle, coincident with gnt_valid falling.
- On any release:
  - Next state is IDLE; gnt=0, gnt_valid=0.
  - ptr = gnt_idx+1 mod 8.
  - gnt_idx keeps its last value.
- Every handover has one IDLE dead cycle, so the minimum spacing between grants is 2 cycles and the resource is never double-selected.
- Maximum grant length is HOLD_MAX cycles.
- Simultaneous events:
  - done together with timeout condition: done wins, timeout=0.
  - Other requests arriving mid-grant are ignored until IDLE.
- Fairness: with all 8 requesting continuously, grants rotate 0,1,...,7,0.
- Reset mid-grant: gnt drops immediately (asynchronous); ptr returns to 0.
- timeout deasserts on the cycle after its pulse.

Test Plan:
- Reset: rst_n=0 with req=8'hFF -> gnt=0, gnt_valid=0, timeout=0. Release rst_n, hold req=8'hFF -> next cycle gnt=8'h01, gnt_idx=0.
- Rotation: req=8'hFF, done pulsed 1 cycle after every grant -> gnt sequence 01,02,04,...,80,01, each separated by one cycle of gnt=0.
- Skip and wrap: after a grant to idx 6 is released, req=8'b0000_0101 -> next grant idx 0, then idx 2; idx 7 is skipped.
- Timeout: HOLD_MAX=16, req=8'h08 held, done never asserted -> gnt=8'h08 for exactly 16 cycles, timeout=1 on the cycle gnt_valid falls. The next grant goes to idx 3 again only after the IDLE cycle, since it is the sole requester.
- Abandon and collision: owner idx 4 drops req[4] at cycle 3 of its grant -> release next edge, timeout=0. In a separate run, done and cnt=HOLD_MAX-1 occur on the same cycle -> timeout stays 0.
- Async reset mid-grant: gnt=8'h20, rst_n pulsed low between clock edges -> gnt=0 immediately, before the next clk edge. After release with req=8'hFF -> grant to idx 0.

Source files
------------

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
//
// Round-robin arbiter that lends one 8-way decoded resource (chip-select /
// enable bus) to one of 8 requesters at a time. The winner is held as a 3-bit
// index and driven as the matching one-hot select line. A grant ends when the
// owner pulses done_i, drops its request, or has held the resource for
// HOLD_MAX cycles (forced release, flagged by a one-cycle timeout_o pulse).
// Every handover passes through one idle cycle, so two grants never overlap.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_i[7:0]   request vector, bit k = requester k
//   done_i       release strobe from the current owner (ignored while idle)
//   gnt_o[7:0]   one-hot grant, decode of gnt_idx_o while gnt_valid_o, else 0
//   gnt_idx_o    index of the current (or most recent) owner
//   gnt_valid_o  grant active
//   timeout_o    one-cycle pulse coincident with a forced release
module rr_decode_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  localparam int unsigned CW      = $clog2(HOLD_MAX)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [7:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : gen_hold_max_check
    $error("rr_decode_arbiter: HOLD_MAX must be within 2..256");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [CW-1:0] CntMax = CW'(HOLD_MAX - 1);

  state_e        state_q;
  logic [2:0]    ptr_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    gnt_q;
  logic [2:0]    gnt_idx_q;
  logic          gnt_valid_q;
  logic          timeout_q;

  // Winner search: rotate the request vector so that bit 0 lines up with the
  // pointer, pick the lowest set bit, then add the pointer back (mod 8).
  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  win_off;
  logic [2:0]  win_idx;
  logic        any_req;

  always_comb begin
    req_dbl = {req_i, req_i};
    req_rot = req_dbl[ptr_q +: 8];
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 3'(i);
      end
    end
    win_idx = ptr_q + win_off;
    any_req = |req_i;
  end

  // Release conditions while a grant is active, in priority order:
  // done, owner abandoned, hold limit reached.
  logic owner_req;
  logic cnt_at_max;
  logic release_now;

  always_comb begin
    owner_req   = req_i[gnt_idx_q];
    cnt_at_max  = (cnt_q == CntMax);
    release_now = done_i || !owner_req || cnt_at_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 3'd0;
      cnt_q       <= '0;
      gnt_q       <= 8'h00;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q     <= StGrant;
            gnt_idx_q   <= win_idx;
            gnt_q       <= 8'b1 << win_idx;
            gnt_valid_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        StGrant: begin
          if (release_now) begin
            state_q     <= StIdle;
            gnt_q       <= 8'h00;
            gnt_valid_q <= 1'b0;
            ptr_q       <= gnt_idx_q + 3'd1;
            // Only a pure hold-limit release is flagged; done or abandon win.
            timeout_q   <= !done_i && owner_req;
          end else if (!cnt_at_max) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;

endmodule
